dsc_s2b_frame: RTL and testbench

Stochastic-to-binary frame decoder: the receiving end of the deterministic stochastic-computing datapath.
- Consumes the serial product bitstream and the early-shutoff/overflow strobe produced by the cascaded-SNG multipliers.
- Counts ones over one frame and delivers the count and frame length through a one-entry valid/ready output buffer.
- Replaces the free-running output counter with a framed, restartable, back-pressure-aware decoder.

---
 rtl/dsc_pkg.sv | 21 ++
 rtl/dsc_out_buf.sv | 69 ++++++
 rtl/dsc_s2b_frame.sv | 127 ++++++++++++
 tb/tb_dsc_s2b_frame.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dsc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dsc_pkg
// Purpose  : Shared definitions for the deterministic stochastic-computing
//            datapath: frame width default and decoder state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package dsc_pkg;

  // Upstream multiplier geometry; a frame holds every SNG combination.
  localparam int SNG_WIDTH       = 8;
  localparam int NUM_INPUTS      = 4;
  localparam int FRAME_W_DEFAULT = SNG_WIDTH * NUM_INPUTS;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

endpackage : dsc_pkg
`default_nettype wire

// File: rtl/dsc_out_buf.sv
`default_nettype none
// ============================================================================
// Module   : dsc_out_buf
// Purpose  : One-entry valid/ready holding register for decoded frames.
//            A load is accepted when the buffer is empty or is being popped
//            in the same cycle; otherwise the result is discarded and the
//            sticky drop flag is raised.
// Ports    : clk, rst (async, active-low)
//            load, load_z, load_len : result from the frame decoder
//            z, len, out_valid      : held result to the consumer
//            out_ready              : consumer acceptance
//            drop                   : sticky discard indicator
// Revision : 1.0 - initial release
// ============================================================================
module dsc_out_buf
  import dsc_pkg::*;
#(
  parameter int WIDTH = FRAME_W_DEFAULT + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_z,
  input  logic [WIDTH-1:0] load_len,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] len,
  output logic             out_valid,
  output logic             drop
);

  logic [WIDTH-1:0] r_z;
  logic [WIDTH-1:0] r_len;
  logic             r_valid;
  logic             r_drop;
  logic             w_pop;
  logic             w_accept;

  assign w_pop    = r_valid & out_ready;
  // Slot is free either because it is empty or because it empties this cycle.
  assign w_accept = load & (~r_valid | out_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_z     <= '0;
      r_len   <= '0;
      r_valid <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_z     <= load_z;
        r_len   <= load_len;
        r_valid <= 1'b1;
      end else if (w_pop) begin
        r_valid <= 1'b0;
      end
      if (load && !w_accept) begin
        r_drop <= 1'b1;
      end
    end
  end

  assign z         = r_z;
  assign len       = r_len;
  assign out_valid = r_valid;
  assign drop      = r_drop;

endmodule : dsc_out_buf
`default_nettype wire

// File: rtl/dsc_s2b_frame.sv
`default_nettype none
// ============================================================================
// Module   : dsc_s2b_frame
// Purpose  : Stochastic-to-binary frame decoder. Counts ones in the serial
//            product bitstream over one restartable frame and hands the
//            (ones count, frame length) pair to a one-entry output buffer.
// Ports    : clk, rst (async, active-low)
//            start     : opens (or restarts) a frame
//            en        : qualifies sn_in and done
//            sn_in     : serial stochastic bit
//            done      : upstream end-of-frame strobe
//            z, len    : ones count and length of the last completed frame
//            out_valid, out_ready : result handshake
//            busy      : frame in progress
//            drop      : sticky, a completed frame found the buffer full
// Revision : 1.0 - initial release
// ============================================================================
module dsc_s2b_frame
  import dsc_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  input  logic             sn_in,
  input  logic             done,
  output logic [FRAME_W:0] z,
  output logic [FRAME_W:0] len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             drop
);

  // Bit count of the last bit before the maximum-length frame closes.
  localparam logic [FRAME_W:0] c_last_bit = {1'b0, {FRAME_W{1'b1}}};
  localparam logic [FRAME_W:0] c_one      = {{FRAME_W{1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [FRAME_W:0] r_ones;
  logic [FRAME_W:0] r_bits;
  logic             w_accum;
  logic             w_frame_end;
  logic [FRAME_W:0] w_z;
  logic [FRAME_W:0] w_len;

  assign w_accum = (r_state == ACCUM);

  // A restart outranks a coincident frame end, so nothing is emitted then.
  assign w_frame_end = w_accum & en & ~start & (done | (r_bits == c_last_bit));

  // The ending bit is always part of the result.
  assign w_z   = r_ones + {{FRAME_W{1'b0}}, sn_in};
  assign w_len = r_bits + c_one;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (start) begin
          w_state_nxt = ACCUM;
        end else if (w_frame_end) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Counters. The start cycle never samples a bit. After a frame end the
  // counters are left as-is; the next start clears them.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ones <= '0;
      r_bits <= '0;
    end else if (start) begin
      r_ones <= '0;
      r_bits <= '0;
    end else if (w_accum && en) begin
      r_ones <= w_z;
      r_bits <= w_len;
    end
  end

  assign busy = w_accum;

  // --------------------------------------------------------------------------
  // Output buffer
  // --------------------------------------------------------------------------
  dsc_out_buf #(
    .WIDTH (FRAME_W + 1)
  ) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (w_frame_end),
    .load_z    (w_z),
    .load_len  (w_len),
    .out_ready (out_ready),
    .z         (z),
    .len       (len),
    .out_valid (out_valid),
    .drop      (drop)
  );

endmodule : dsc_s2b_frame
`default_nettype wire

// File: tb/tb_dsc_s2b_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsc_s2b_frame
// Purpose  : Directed self-checking bench for dsc_s2b_frame. One instance at
//            FRAME_W=4 for the functional scenarios, one at the default width
//            for the long-frame scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsc_s2b_frame;

  logic       clk;
  logic       rst;
  logic       start, en, sn_in, done, out_ready;
  logic [4:0] z, len;
  logic       out_valid, busy, drop;

  logic        start2, en2, sn2, done2, ready2;
  logic [32:0] z2, len2;
  logic        valid2, busy2, drop2;

  int n_pass;
  int n_total;

  dsc_s2b_frame #(.FRAME_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .en(en), .sn_in(sn_in), .done(done),
    .z(z), .len(len), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .drop(drop)
  );

  dsc_s2b_frame dut_wide (
    .clk(clk), .rst(rst), .start(start2), .en(en2), .sn_in(sn2), .done(done2),
    .z(z2), .len(len2), .out_valid(valid2), .out_ready(ready2),
    .busy(busy2), .drop(drop2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b, input logic d);
    en = 1'b1; sn_in = b; done = d;
    tick();
    en = 1'b0; sn_in = 1'b0; done = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #3;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    n_total++; if ({z, len, out_valid, busy, drop} !== 13'd0) $display("FAIL reset_outs: got %b expected 0", {z, len, out_valid, busy, drop}); else n_pass++;
    n_total++; if ({z2, len2, valid2, busy2, drop2} !== 69'd0) $display("FAIL reset_wide: got %0h expected 0", {z2, len2, valid2, busy2, drop2}); else n_pass++;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_full_frame();
    do_start();
    n_total++; if (busy !== 1'b1) $display("FAIL full_busy: got %b expected 1", busy); else n_pass++;
    for (int i = 0; i < 15; i++) send_bit((i % 2 == 0) && (i < 12), 1'b0);
    n_total++; if (out_valid !== 1'b0) $display("FAIL full_early_valid: got %b expected 0", out_valid); else n_pass++;
    send_bit(1'b0, 1'b0);
    n_total++; if (out_valid !== 1'b1) $display("FAIL full_valid: got %b expected 1", out_valid); else n_pass++;
    n_total++; if (z !== 5'd6 || len !== 5'd16) $display("FAIL full_result: got z=%0d len=%0d expected z=6 len=16", z, len); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL full_busy_end: got %b expected 0", busy); else n_pass++;
    pop();
    n_total++; if (out_valid !== 1'b0 || z !== 5'd6) $display("FAIL full_pop: got valid=%b z=%0d expected valid=0 z=6", out_valid, z); else n_pass++;
  endtask

  task automatic test_early_shutoff();
    do_start();
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    n_total++; if (out_valid !== 1'b1 || z !== 5'd3 || len !== 5'd4) $display("FAIL early_result: got v=%b z=%0d len=%0d expected v=1 z=3 len=4", out_valid, z, len); else n_pass++;
    pop();
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b1);
    n_total++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL early_idle_bits: got v=%b busy=%b expected 0 0", out_valid, busy); else n_pass++;
  endtask

  task automatic test_all_ones();
    do_start();
    for (int i = 0; i < 16; i++) send_bit(1'b1, 1'b0);
    n_total++; if (out_valid !== 1'b1 || z !== 5'd16 || len !== 5'd16) $display("FAIL all_ones: got v=%b z=%0d len=%0d expected v=1 z=16 len=16", out_valid, z, len); else n_pass++;
    pop();
  endtask

  task automatic test_en_gaps();
    do_start();
    send_bit(1'b1, 1'b0);
    sn_in = 1'b1; done = 1'b1;
    tick(); tick();
    sn_in = 1'b0; done = 1'b0;
    n_total++; if (busy !== 1'b1 || out_valid !== 1'b0) $display("FAIL gap_hold: got busy=%b v=%b expected 1 0", busy, out_valid); else n_pass++;
    send_bit(1'b1, 1'b1);
    n_total++; if (out_valid !== 1'b1 || z !== 5'd2 || len !== 5'd2) $display("FAIL gap_result: got v=%b z=%0d len=%0d expected v=1 z=2 len=2", out_valid, z, len); else n_pass++;
    pop();
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    do_start();
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    do_start();
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    n_total++; if (out_valid !== 1'b1 || z !== 5'd2 || len !== 5'd2) $display("FAIL bp_held: got v=%b z=%0d len=%0d expected v=1 z=2 len=2", out_valid, z, len); else n_pass++;
    n_total++; if (drop !== 1'b1) $display("FAIL bp_drop: got %b expected 1", drop); else n_pass++;
    do_reset();
    n_total++; if (drop !== 1'b0 || out_valid !== 1'b0) $display("FAIL bp_reset: got drop=%b v=%b expected 0 0", drop, out_valid); else n_pass++;
    do_start();
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    do_start();
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    out_ready = 1'b1;
    send_bit(1'b0, 1'b1);
    out_ready = 1'b0;
    n_total++; if (out_valid !== 1'b1 || z !== 5'd1 || len !== 5'd3 || drop !== 1'b0) $display("FAIL bp_pop_load: got v=%b z=%0d len=%0d drop=%b expected v=1 z=1 len=3 drop=0", out_valid, z, len, drop); else n_pass++;
    pop();
  endtask

  task automatic test_abort();
    do_start();
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    do_start();
    n_total++; if (out_valid !== 1'b0 || busy !== 1'b1) $display("FAIL abort_no_emit: got v=%b busy=%b expected 0 1", out_valid, busy); else n_pass++;
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    n_total++; if (out_valid !== 1'b1 || z !== 5'd1 || len !== 5'd2) $display("FAIL abort_result: got v=%b z=%0d len=%0d expected v=1 z=1 len=2", out_valid, z, len); else n_pass++;
    pop();
    // Restart coinciding with a done bit: the restart wins.
    do_start();
    send_bit(1'b1, 1'b0);
    start = 1'b1;
    send_bit(1'b1, 1'b1);
    start = 1'b0;
    n_total++; if (out_valid !== 1'b0 || busy !== 1'b1) $display("FAIL start_wins: got v=%b busy=%b expected 0 1", out_valid, busy); else n_pass++;
    send_bit(1'b1, 1'b1);
    n_total++; if (out_valid !== 1'b1 || z !== 5'd1 || len !== 5'd1) $display("FAIL start_wins_result: got v=%b z=%0d len=%0d expected v=1 z=1 len=1", out_valid, z, len); else n_pass++;
    pop();
  endtask

  task automatic test_async_reset();
    do_start();
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    do_start();
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    n_total++; if ({z, len, out_valid, busy, drop} !== 13'd0) $display("FAIL async_reset: got %b expected 0", {z, len, out_valid, busy, drop}); else n_pass++;
    rst = 1'b1;
    tick();
    send_bit(1'b1, 1'b1);
    n_total++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL async_reset_idle: got v=%b busy=%b expected 0 0", out_valid, busy); else n_pass++;
  endtask

  task automatic test_wide();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      en2 = 1'b1; sn2 = (i <= 37); done2 = (i == 100);
      tick();
    end
    en2 = 1'b0; sn2 = 1'b0; done2 = 1'b0;
    n_total++; if (valid2 !== 1'b1 || z2 !== 33'd37 || len2 !== 33'd100) $display("FAIL wide_result: got v=%b z=%0d len=%0d expected v=1 z=37 len=100", valid2, z2, len2); else n_pass++;
    n_total++; if (busy2 !== 1'b0 || drop2 !== 1'b0) $display("FAIL wide_status: got busy=%b drop=%b expected 0 0", busy2, drop2); else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst = 1'b0;
    start = 1'b0; en = 1'b0; sn_in = 1'b0; done = 1'b0; out_ready = 1'b0;
    start2 = 1'b0; en2 = 1'b0; sn2 = 1'b0; done2 = 1'b0; ready2 = 1'b0;
    test_reset();
    test_full_frame();
    test_early_shutoff();
    test_all_ones();
    test_en_gaps();
    test_back_pressure();
    test_abort();
    test_async_reset();
    test_wide();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_dsc_s2b_frame
`default_nettype wire
